div_sched: RTL and testbench
============================

// Module: div_sched
// PURPOSE
// Multi-cycle scheduler for RV32M DIV/DIVU/REM/REMU beside the execute stage.
// EX pulses start_i for a divide instruction; this block stalls the pipeline via
// hold_flag_o, runs a radix-2 restoring divider one quotient bit per cycle and
// returns the rd write-back for one cycle. Special cases finish early.
// PARAMETERS
// DATA_W  32  operand/result width (RV32 = 32)
// CNT_W   6   iteration counter width; must hold DATA_W
// PORTS
// clk          in   1       core clock
// rst          in   1       asynchronous active-high reset
// start_i      in   1       one-cycle request from EX (valid divide instruction)
// op_i         in   2       func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
// dividend_i   in   DATA_W  rs1 value (op1)
// divisor_i    in   DATA_W  rs2 value (op2)
// rd_addr_i    in   5       destination register
// flush_i      in   1       pipeline flush from ctrl (jump taken); aborts op
// hold_flag_o  out  1       stall request to ctrl
// busy_o       out  1       state != IDLE
// rd_data_o    out  DATA_W  result, valid when rd_wen_o=1
// rd_addr_o    out  5       destination, valid when rd_wen_o=1
// rd_wen_o     out  1       one-cycle write-back strobe
// BEHAVIOUR
// - Reset: state IDLE, counter 0, all captured regs 0; every output 0.
// - FSM states IDLE, CALC, DONE.
//   IDLE: on start_i & ~flush_i capture op, rd_addr, operand signs.
//     divisor==0 -> DONE; quotient=all ones, remainder=dividend.
//     signed op & dividend==0x8000_0000 & divisor==all ones -> DONE;
//       quotient=0x8000_0000, remainder=0.
//     otherwise -> CALC, counter=0, operands made absolute for signed ops.
//   CALC: per cycle rem'={rem,dvd[MSB]}; if rem'>=divisor subtract, q bit=1;
//     shift dividend left; counter++; after DATA_W iterations -> DONE.
//   DONE: apply sign; quotient negated if signed & sign(dividend)^sign(divisor);
//     remainder negated if signed & sign(dividend); rd_wen_o=1; -> IDLE.
// - Latency (start sampled at cycle 0): normal DONE at cycle DATA_W+1 (33);
//   special cases DONE at cycle 1. rd_data/rd_addr/rd_wen registered, DONE only.
// - hold_flag_o = (IDLE & start_i & ~flush_i) | CALC | (IDLE->DONE special
//   path cycle 0); low in DONE so the pipeline advances with the write-back.
// - start_i while busy: ignored (EX is held); bench asserts it never occurs.
// - flush_i in any state: next state IDLE, no rd_wen_o; flush_i with start_i in
//   IDLE: request dropped, hold_flag_o stays 0. flush_i in DONE suppresses wen.
// - op_i[1] selects remainder, op_i[0]=1 unsigned; unsigned ops skip abs/negate.
// - Async rst mid-operation: immediate IDLE, outputs 0, no write-back.
// TESTING
// - DIV 20/3, rd=5 -> hold 0..32, cycle 33 rd_wen=1, rd_data=6, rd_addr=5.
// - DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; REMU 20/3 -> 2.
// - DIVU 7/0 -> cycle 1 rd_data=0xFFFFFFFF; REM 7/0 -> 7; hold only cycle 0.
// - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 cycle 1; REM same -> 0.
// - DIV 100/7, flush_i at cycle 10 -> IDLE cycle 11, no rd_wen, hold low.
// - rst pulse at cycle 15 of DIVU -> outputs 0 immediately; new op completes.

Source files
------------

// File: rtl/div_sched_if.sv
// Request/write-back bundle between the EX stage and the divide scheduler.
interface div_sched_if #(
    parameter int DATA_W = 32
) ();
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        rd_addr_i;
    logic              flush_i;
    logic              hold_flag_o;
    logic              busy_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [4:0]        rd_addr_o;
    logic              rd_wen_o;

    // EX / control side: issues requests, observes stall and write-back
    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        input  hold_flag_o, busy_o, rd_data_o, rd_addr_o, rd_wen_o
    );

    // Divider side
    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        output hold_flag_o, busy_o, rd_data_o, rd_addr_o, rd_wen_o
    );
endinterface

// File: rtl/div_sched.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU scheduler: radix-2 restoring divider,
// one quotient bit per cycle, with early completion for divide-by-zero and
// signed overflow. Stalls the pipeline while working and returns a one-cycle
// rd write-back strobe.
module div_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [1:0]        op_q;
    logic [4:0]        rd_addr_q;
    logic              sign_dvd_q;
    logic              sign_dvs_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] res_q;

    logic              accept;
    logic              is_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic              div_zero;
    logic              overflow;
    logic              special;
    logic [DATA_W-1:0] special_res;
    logic [DATA_W-1:0] abs_dvd;
    logic [DATA_W-1:0] abs_dvs;
    logic              last_iter;
    logic              hold;

    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;
    logic [DATA_W-1:0] quo_fin;
    logic [DATA_W-1:0] rem_fin;
    logic [DATA_W-1:0] res_calc;

    // Request decode, special-case detection and one restoring-division step
    always_comb begin
        accept      = (state_q == IDLE) && bus.start_i && !bus.flush_i;
        is_signed   = !bus.op_i[0];
        dvd_neg     = is_signed && bus.dividend_i[DATA_W-1];
        dvs_neg     = is_signed && bus.divisor_i[DATA_W-1];
        div_zero    = (bus.divisor_i == '0);
        overflow    = is_signed
                      && (bus.dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                      && (bus.divisor_i == '1);
        special     = div_zero || overflow;
        special_res = '0;
        if (bus.op_i[1]) begin
            special_res = div_zero ? bus.dividend_i : '0;
        end else begin
            special_res = div_zero ? '1 : {1'b1, {(DATA_W-1){1'b0}}};
        end
        abs_dvd     = dvd_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
        abs_dvs     = dvs_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
        last_iter   = (cnt_q == CNT_W'(DATA_W - 1));

        trial    = {rem_q, dvd_q[DATA_W-1]};
        diff     = trial - {1'b0, dvs_q};
        ge       = (trial >= {1'b0, dvs_q});
        rem_n    = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_n    = {quo_q[DATA_W-2:0], ge};
        quo_fin  = (!op_q[0] && (sign_dvd_q ^ sign_dvs_q)) ? (~quo_n + 1'b1) : quo_n;
        rem_fin  = (!op_q[0] && sign_dvd_q) ? (~rem_n + 1'b1) : rem_n;
        res_calc = op_q[1] ? rem_fin : quo_fin;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall request; a flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold    = 1'b1;
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                hold = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, latch final result on the
    // edge that enters DONE so the write-back comes straight from a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            rd_addr_q  <= '0;
            sign_dvd_q <= 1'b0;
            sign_dvs_q <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= bus.op_i;
                        rd_addr_q  <= bus.rd_addr_i;
                        sign_dvd_q <= dvd_neg;
                        sign_dvs_q <= dvs_neg;
                        if (special) begin
                            res_q <= special_res;
                        end else begin
                            dvd_q <= abs_dvd;
                            dvs_q <= abs_dvs;
                            rem_q <= '0;
                            quo_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush_i) begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            res_q <= res_calc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: write-back only in DONE, and a flush there cancels it
    always_comb begin
        bus.hold_flag_o = hold;
        bus.busy_o      = (state_q != IDLE);
        bus.rd_wen_o    = (state_q == DONE) && !bus.flush_i;
        bus.rd_data_o   = (state_q == DONE) ? res_q : '0;
        bus.rd_addr_o   = (state_q == DONE) ? rd_addr_q : '0;
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: table of divide vectors with expected result
// and latency, plus flush, dropped-request and async-reset sequences.
module tb_div_sched;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;

    div_sched_if #(.DATA_W(32)) bus ();

    div_sched #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int unsigned lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // EX never issues while the divider is busy
    always @(posedge clk) begin
        if (!rst && bus.busy_o && bus.start_i) begin
            errors++;
            $display("FAIL start_while_busy: got 1 expected 0");
        end
    end

    task automatic run_vec(input int unsigned idx, input vec_t v);
        int unsigned lat;
        logic        seen;
        logic        hold_ok;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = v.op;
        bus.dividend_i = v.a;
        bus.divisor_i  = v.b;
        bus.rd_addr_i  = v.rd;
        #1 check($sformatf("v%0d hold_c0", idx), 32'(bus.hold_flag_o), 32'd1);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        seen    = 1'b0;
        lat     = 0;
        hold_ok = 1'b1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.rd_wen_o) begin
                seen = 1'b1;
                lat  = c;
                check($sformatf("v%0d rd_data", idx), bus.rd_data_o, v.exp);
                check($sformatf("v%0d rd_addr", idx), 32'(bus.rd_addr_o), 32'(v.rd));
                check($sformatf("v%0d hold_done", idx), 32'(bus.hold_flag_o), 32'd0);
            end else if (!bus.hold_flag_o || !bus.busy_o) begin
                hold_ok = 1'b0;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d hold_calc", idx), 32'(hold_ok), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), {30'd0, bus.busy_o, bus.rd_wen_o}, 32'd0);
    endtask

    initial begin
        int unsigned wen_seen;
        checks = 0;
        errors = 0;

        // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
        vecs[0]  = '{2'b00, 32'd20,        32'd3,         5'd5,  32'd6,         33};
        vecs[1]  = '{2'b00, 32'hFFFF_FFEC, 32'd3,         5'd6,  32'hFFFF_FFFA, 33};
        vecs[2]  = '{2'b10, 32'hFFFF_FFEC, 32'd3,         5'd7,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{2'b11, 32'd20,        32'd3,         5'd8,  32'd2,         33};
        vecs[4]  = '{2'b01, 32'd7,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[5]  = '{2'b10, 32'd7,         32'd0,         5'd10, 32'd7,         1};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        vecs[8]  = '{2'b00, 32'd0,         32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         33};
        vecs[10] = '{2'b00, 32'd20,        32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, 33};
        vecs[11] = '{2'b10, 32'd20,        32'hFFFF_FFFD, 5'd16, 32'd2,         33};
        vecs[12] = '{2'b01, 32'hFFFF_FFFF, 32'd1,         5'd17, 32'hFFFF_FFFF, 33};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        5'd18, 32'd5,         33};
        vecs[14] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd19, 32'd3,         33};
        vecs[15] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFF, 33};
        vecs[16] = '{2'b00, 32'h8000_0000, 32'd2,         5'd21, 32'hC000_0000, 33};
        vecs[17] = '{2'b11, 32'd7,         32'd0,         5'd31, 32'd7,         1};

        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.op_i       = '0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.rd_addr_i  = '0;
        bus.flush_i    = 1'b0;
        #1;
        check("reset_ctrl", {27'd0, bus.hold_flag_o, bus.busy_o, bus.rd_wen_o, 2'b00}, 32'd0);
        check("reset_data", bus.rd_data_o, 32'd0);
        check("reset_addr", 32'(bus.rd_addr_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 18; i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush at cycle 10 of DIV 100/7: back to IDLE, no write-back
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b00;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.rd_addr_i  = 5'd4;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        check("flush_c10_busy", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_c11", {29'd0, bus.busy_o, bus.hold_flag_o, bus.rd_wen_o}, 32'd0);
        wen_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rd_wen_o || bus.busy_o) wen_seen++;
        end
        check("flush_no_wb", 32'(wen_seen), 32'd0);

        // start together with flush in IDLE: request dropped
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        #1 check("drop_hold", 32'(bus.hold_flag_o), 32'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("drop_busy", {30'd0, bus.busy_o, bus.rd_wen_o}, 32'd0);

        // Flush during DONE of a special case suppresses the write-back
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b01;
        bus.dividend_i = 32'd9;
        bus.divisor_i  = 32'd0;
        bus.rd_addr_i  = 5'd22;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        #1 check("flush_done_wen", 32'(bus.rd_wen_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_done_idle", 32'(bus.busy_o), 32'd0);

        // Async reset at cycle 15 of DIVU: outputs clear immediately
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b01;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd7;
        bus.rd_addr_i  = 5'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        check("rst_pre_busy", 32'(bus.busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_ctrl", {29'd0, bus.busy_o, bus.hold_flag_o, bus.rd_wen_o}, 32'd0);
        check("rst_data", bus.rd_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wen_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rd_wen_o || bus.busy_o) wen_seen++;
        end
        check("rst_no_wb", 32'(wen_seen), 32'd0);
        run_vec(100, '{2'b01, 32'd1000, 32'd7, 5'd3, 32'd142, 33});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
